// File: rtl/led_frame_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// led_frame_driver
//
// Serialises one frame of LED colour data onto a two-wire (data + clock) LED
// strip. A frame is built from a small table of colour bins: bin i supplies
// counts[i] consecutive pixels, starting at bin 0. Two framings are supported:
//   MODE 0 : raw 24-bit {R,G,B} words (WS2801 style).
//   MODE 1 : APA102 frames -- 32-bit zero start frame, 32-bit pixel words
//            {3'b111, brightness, B, G, R}, then 8*ceil(LEDS/16) one bits.
// Every frame ends with a latch period where both lines are held low.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   frame request, only looked at while idle
//   rgb        in   per-bin colour, [23:16]=R [15:8]=G [7:0]=B
//   counts     in   number of LEDs taken from each bin
//   brightness in   APA102 global brightness (unused in MODE 0)
//   dOut       out  serial data
//   clkOut     out  serial clock
//   busy       out  high whenever a frame is in progress
//   done       out  one-cycle pulse when a frame (including latch) completes
// -----------------------------------------------------------------------------
module led_frame_driver #(
    parameter int LEDS         = 50,
    parameter int BIN_QTY      = 12,
    parameter int CLK_DIV      = 4,
    parameter int MODE         = 0,
    parameter int LATCH_CYCLES = 6250
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [BIN_QTY-1:0][23:0]               rgb,
    input  logic [BIN_QTY-1:0][$clog2(LEDS+1)-1:0] counts,
    input  logic [4:0]                             brightness,
    output logic                                   dOut,
    output logic                                   clkOut,
    output logic                                   busy,
    output logic                                   done
);

    localparam int CW        = $clog2(LEDS + 1);
    localparam int AW        = CW + 1;
    localparam int DW        = $clog2(CLK_DIV);
    localparam int HALF      = CLK_DIV / 2;
    localparam int LW        = $clog2(LATCH_CYCLES + 1);
    localparam int WORD_BITS = (MODE == 1) ? 32 : 24;
    localparam int EOF_BITS  = 8 * ((LEDS + 15) / 16);
    localparam int BCW       = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOF   = 3'd1,
        ST_PIXEL = 3'd2,
        ST_EOF   = 3'd3,
        ST_LATCH = 3'd4
    } state_t;

    // Left-aligned pixel word; MODE 0 uses only the top 24 bits.
    function automatic logic [31:0] fmt_word(input logic [23:0] color,
                                             input logic [4:0]  bright);
        logic [31:0] word;
        if (MODE == 1) begin
            word = {3'b111, bright, color[7:0], color[15:8], color[23:16]};
        end else begin
            word = {color, 8'h00};
        end
        return word;
    endfunction

    state_t                         state_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           dout_q;
    logic                           clkout_q;
    logic [DW-1:0]                  div_q;
    logic [BCW-1:0]                 bit_cnt_q;
    logic [CW-1:0]                  pix_q;
    logic [LW-1:0]                  latch_q;
    logic [BIN_QTY-1:0][23:0]       rgb_q;
    logic [BIN_QTY-1:0][CW-1:0]     counts_q;
    logic [4:0]                     bright_q;

    logic [AW-1:0]                  acc_s;
    logic [23:0]                    color_s;
    logic [31:0]                    pix_word_s;
    logic                           cur_bit_s;
    logic                           clk_hi_s;
    logic                           bit_end_s;
    logic                           word_last_s;
    logic                           sof_last_s;
    logic                           eof_last_s;
    logic                           pix_last_s;

    // Colour of the current pixel: the highest nonzero bin whose first pixel
    // is at or before pix_q. Inside a bin's range that bin wins; past the sum
    // of counts the last nonzero bin keeps repeating; zero-count bins never
    // match, so they cost no time. The running start index saturates at
    // LEDS, which keeps truncated bins out and means the sum never wraps.
    always_comb begin
        acc_s   = {AW{1'b0}};
        color_s = 24'h000000;
        for (int i = 0; i < BIN_QTY; i++) begin
            color_s = ((counts_q[i] != {CW{1'b0}}) && ({1'b0, pix_q} >= acc_s))
                      ? rgb_q[i] : color_s;
            acc_s   = acc_s + {1'b0, counts_q[i]};
            acc_s   = (acc_s > AW'(LEDS)) ? AW'(LEDS) : acc_s;
        end
    end

    // Bit to present in the current bit period and bit-timing flags.
    always_comb begin
        pix_word_s  = fmt_word(color_s, bright_q);
        clk_hi_s    = (div_q >= DW'(HALF));
        bit_end_s   = (div_q == DW'(CLK_DIV - 1));
        word_last_s = (bit_cnt_q == BCW'(WORD_BITS - 1));
        sof_last_s  = (bit_cnt_q == BCW'(31));
        eof_last_s  = (bit_cnt_q == BCW'(EOF_BITS - 1));
        pix_last_s  = (pix_q == CW'(LEDS - 1));
        case (state_q)
            ST_SOF:   cur_bit_s = 1'b0;
            ST_PIXEL: cur_bit_s = pix_word_s[5'd31 - bit_cnt_q[4:0]];
            ST_EOF:   cur_bit_s = 1'b1;
            default:  cur_bit_s = 1'b0;
        endcase
    end

    // Frame FSM. Outputs are registered from the current state, so the line
    // pattern trails the state by one cycle; the latch state therefore runs
    // one extra cycle so the lines stay low for the full latch period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= 1'b0;
            clkout_q  <= 1'b0;
            div_q     <= {DW{1'b0}};
            bit_cnt_q <= {BCW{1'b0}};
            pix_q     <= {CW{1'b0}};
            latch_q   <= {LW{1'b0}};
            rgb_q     <= '0;
            counts_q  <= '0;
            bright_q  <= 5'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    dout_q   <= 1'b0;
                    clkout_q <= 1'b0;
                    if (start) begin
                        rgb_q     <= rgb;
                        counts_q  <= counts;
                        bright_q  <= brightness;
                        div_q     <= {DW{1'b0}};
                        bit_cnt_q <= {BCW{1'b0}};
                        pix_q     <= {CW{1'b0}};
                        latch_q   <= {LW{1'b0}};
                        busy_q    <= 1'b1;
                        state_q   <= (MODE == 1) ? ST_SOF : ST_PIXEL;
                    end
                end

                ST_SOF: begin
                    dout_q   <= cur_bit_s;
                    clkout_q <= clk_hi_s;
                    if (bit_end_s) begin
                        div_q <= {DW{1'b0}};
                        if (sof_last_s) begin
                            bit_cnt_q <= {BCW{1'b0}};
                            state_q   <= ST_PIXEL;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end

                ST_PIXEL: begin
                    dout_q   <= cur_bit_s;
                    clkout_q <= clk_hi_s;
                    if (bit_end_s) begin
                        div_q <= {DW{1'b0}};
                        if (word_last_s) begin
                            bit_cnt_q <= {BCW{1'b0}};
                            if (pix_last_s) begin
                                state_q <= (MODE == 1) ? ST_EOF : ST_LATCH;
                            end else begin
                                pix_q <= pix_q + CW'(1);
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end

                ST_EOF: begin
                    dout_q   <= cur_bit_s;
                    clkout_q <= clk_hi_s;
                    if (bit_end_s) begin
                        div_q <= {DW{1'b0}};
                        if (eof_last_s) begin
                            bit_cnt_q <= {BCW{1'b0}};
                            state_q   <= ST_LATCH;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end

                ST_LATCH: begin
                    dout_q   <= 1'b0;
                    clkout_q <= 1'b0;
                    if (latch_q == LW'(LATCH_CYCLES)) begin
                        latch_q <= {LW{1'b0}};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        latch_q <= latch_q + LW'(1);
                    end
                end

                default: begin
                    dout_q   <= 1'b0;
                    clkout_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign dOut   = dout_q;
    assign clkOut = clkout_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_led_frame_driver.sv
`timescale 1ns/1ps
// Bench for led_frame_driver: three instances cover MODE 0 (LEDS=4, LEDS=6
// with CLK_DIV=2) and MODE 1 (LEDS=3). A negedge monitor decodes the serial
// stream on clkOut rising edges and records per-frame timing.
module tb_led_frame_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start0, start1, start2;
    logic [2:0][23:0]  rgb0, rgb1;
    logic [0:0][23:0]  rgb2;
    logic [2:0][2:0]   cnt0, cnt1;
    logic [0:0][1:0]   cnt2;
    logic [4:0]        br0, br1, br2;
    wire  [2:0]        dq, cq, bq, oq;

    int checks   = 0;
    int failures = 0;

    led_frame_driver #(.LEDS(4), .BIN_QTY(3), .CLK_DIV(4), .MODE(0), .LATCH_CYCLES(8)) u0 (
        .clk(clk), .rst(rst), .start(start0), .rgb(rgb0), .counts(cnt0), .brightness(br0),
        .dOut(dq[0]), .clkOut(cq[0]), .busy(bq[0]), .done(oq[0]));
    led_frame_driver #(.LEDS(6), .BIN_QTY(3), .CLK_DIV(2), .MODE(0), .LATCH_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .rgb(rgb1), .counts(cnt1), .brightness(br1),
        .dOut(dq[1]), .clkOut(cq[1]), .busy(bq[1]), .done(oq[1]));
    led_frame_driver #(.LEDS(3), .BIN_QTY(1), .CLK_DIV(4), .MODE(1), .LATCH_CYCLES(5)) u2 (
        .clk(clk), .rst(rst), .start(start2), .rgb(rgb2), .counts(cnt2), .brightness(br2),
        .dOut(dq[2]), .clkOut(cq[2]), .busy(bq[2]), .done(oq[2]));

    int          nbits[3], blen[3], idle_run[3], gap[3], first_rise[3], hi_cnt[3];
    int          dones[3], frames[3], viol[3];
    int          fn[3], flen[3], frise[3], fhi[3];
    logic [0:255] bits[3], fbits[3];
    logic [2:0]  pb = 3'b000;
    logic [2:0]  pc = 3'b000;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (bq[k] && !pb[k]) begin
                nbits[k] = 0; blen[k] = 0; hi_cnt[k] = 0; first_rise[k] = -1;
                gap[k] = idle_run[k];
            end
            if (bq[k]) begin
                blen[k]++; idle_run[k] = 0;
            end else begin
                idle_run[k]++;
                if (cq[k] || dq[k]) viol[k]++;
            end
            if (cq[k]) hi_cnt[k]++;
            if (cq[k] && !pc[k]) begin
                if (first_rise[k] < 0) first_rise[k] = blen[k] - 1;
                if (nbits[k] < 256) bits[k][nbits[k]] = dq[k];
                nbits[k]++;
            end
            if (!bq[k] && pb[k]) begin
                fbits[k] = bits[k]; fn[k] = nbits[k]; flen[k] = blen[k];
                frise[k] = first_rise[k]; fhi[k] = hi_cnt[k]; frames[k]++;
            end
            if (oq[k]) dones[k]++;
        end
        pb = bq;
        pc = cq;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse0();
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
    endtask

    task automatic wait_done(input int k, input int target, input int budget, input string tag);
        int n = 0;
        while (dones[k] < target && n < budget) begin
            tick(1);
            n++;
        end
        check_eq(tag, 64'(dones[k] >= target), 64'd1);
    endtask

    function automatic logic [23:0] w24(input int k, input int j);
        return fbits[k][j*24 +: 24];
    endfunction

    logic [23:0] exp1 [6] = '{24'hAA0000, 24'hAA0000, 24'h123456, 24'h123456, 24'h123456, 24'h123456};
    logic [23:0] expa [4] = '{24'hFF0000, 24'h00FF00, 24'h00FF00, 24'h0000FF};
    logic [23:0] expo [4] = '{24'h111111, 24'h111111, 24'h111111, 24'h222222};
    logic [23:0] exph [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h070809};
    int          dsave;

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        rgb0 = '0; rgb1 = '0; rgb2 = '0; cnt0 = '0; cnt1 = '0; cnt2 = '0;
        br0 = 5'd0; br1 = 5'd0; br2 = 5'd0;
        tick(3);
        check_eq("reset_u0", 64'({bq[0], oq[0], dq[0], cq[0]}), 64'd0);
        check_eq("reset_u2", 64'({bq[2], oq[2], dq[2], cq[2]}), 64'd0);
        rst = 1'b0;

        // Frame A on all three instances, inputs garbled after capture
        rgb0[0] = 24'hFF0000; rgb0[1] = 24'h00FF00; rgb0[2] = 24'h0000FF;
        cnt0[0] = 3'd1; cnt0[1] = 3'd2; cnt0[2] = 3'd1;
        rgb1[0] = 24'hAA0000; rgb1[1] = 24'hBBBBBB; rgb1[2] = 24'h123456;
        cnt1[0] = 3'd2; cnt1[1] = 3'd0; cnt1[2] = 3'd1;
        rgb2[0] = 24'h0A0B0C; cnt2[0] = 2'd3; br2 = 5'd31;
        start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
        tick(1);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        rgb0 = '1; cnt0 = '0; rgb1 = '0; cnt1 = '1; rgb2 = '1; cnt2 = '0; br2 = 5'd0;
        tick(50);
        pulse0();
        wait_done(0, 1, 3000, "timeout_a0");
        wait_done(1, 1, 3000, "timeout_a1");
        wait_done(2, 1, 3000, "timeout_a2");

        check_eq("a0_nbits", 64'(fn[0]), 64'd96);
        for (int j = 0; j < 4; j++) check_eq("a0_pixel", 64'(w24(0, j)), 64'(expa[j]));
        check_eq("a0_busy_len", 64'(flen[0]), 64'd393);
        check_eq("a0_first_rise", 64'(frise[0]), 64'd3);
        check_eq("a0_clk_high", 64'(fhi[0]), 64'd192);
        check_eq("a0_frames", 64'(frames[0]), 64'd1);

        check_eq("a1_nbits", 64'(fn[1]), 64'd144);
        for (int j = 0; j < 6; j++) check_eq("a1_pixel", 64'(w24(1, j)), 64'(exp1[j]));
        check_eq("a1_busy_len", 64'(flen[1]), 64'd292);
        check_eq("a1_first_rise", 64'(frise[1]), 64'd2);

        check_eq("a2_nbits", 64'(fn[2]), 64'd136);
        check_eq("a2_sof", 64'(fbits[2][0 +: 32]), 64'd0);
        for (int j = 0; j < 3; j++) check_eq("a2_pixel", 64'(fbits[2][32 + 32*j +: 32]), 64'hFF0C0B0A);
        check_eq("a2_eof", 64'(fbits[2][128 +: 8]), 64'hFF);
        check_eq("a2_busy_len", 64'(flen[2]), 64'd550);
        check_eq("a2_dones", 64'(dones[2]), 64'd1);

        // Overflow: counts sum past LEDS
        rgb0[0] = 24'h111111; rgb0[1] = 24'h222222; rgb0[2] = 24'h333333;
        cnt0[0] = 3'd3; cnt0[1] = 3'd3; cnt0[2] = 3'd0;
        pulse0();
        wait_done(0, 2, 3000, "timeout_ovf");
        check_eq("ovf_nbits", 64'(fn[0]), 64'd96);
        for (int j = 0; j < 4; j++) check_eq("ovf_pixel", 64'(w24(0, j)), 64'(expo[j]));

        // Underfill: last nonzero bin repeats
        rgb0[0] = 24'hABCDEF;
        cnt0[0] = 3'd1; cnt0[1] = 3'd0; cnt0[2] = 3'd0;
        pulse0();
        wait_done(0, 3, 3000, "timeout_fill");
        for (int j = 0; j < 4; j++) check_eq("fill_pixel", 64'(w24(0, j)), 64'hABCDEF);

        // All counts zero: black frame
        cnt0 = '0;
        pulse0();
        wait_done(0, 4, 3000, "timeout_zero");
        check_eq("zero_nbits", 64'(fn[0]), 64'd96);
        for (int j = 0; j < 4; j++) check_eq("zero_pixel", 64'(w24(0, j)), 64'd0);

        // start held high: two back-to-back frames
        rgb0[0] = 24'h010203; rgb0[1] = 24'h040506; rgb0[2] = 24'h070809;
        cnt0[0] = 3'd1; cnt0[1] = 3'd1; cnt0[2] = 3'd1;
        start0 = 1'b1;
        wait_done(0, 5, 3000, "timeout_held1");
        start0 = 1'b0;
        check_eq("held_restart_busy", 64'(bq[0]), 64'd1);
        wait_done(0, 6, 3000, "timeout_held2");
        check_eq("held_gap", 64'(gap[0]), 64'd1);
        for (int j = 0; j < 4; j++) check_eq("held_pixel", 64'(w24(0, j)), 64'(exph[j]));
        tick(20);
        check_eq("held_no_third", 64'(bq[0]), 64'd0);

        // Reset during pixel 2, then immediate restart
        rgb0[0] = 24'h5A5A5A;
        cnt0[0] = 3'd4; cnt0[1] = 3'd0; cnt0[2] = 3'd0;
        pulse0();
        tick(110);
        check_eq("pre_abort_busy", 64'(bq[0]), 64'd1);
        rst = 1'b1;
        tick(1);
        check_eq("abort_outs", 64'({bq[0], oq[0], dq[0], cq[0]}), 64'd0);
        dsave = dones[0];
        rst = 1'b0;
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        check_eq("abort_no_done", 64'(dones[0]), 64'(dsave));
        check_eq("restart_busy", 64'(bq[0]), 64'd1);
        wait_done(0, 7, 3000, "timeout_restart");
        check_eq("restart_nbits", 64'(fn[0]), 64'd96);
        for (int j = 0; j < 4; j++) check_eq("restart_pixel", 64'(w24(0, j)), 64'h5A5A5A);
        check_eq("restart_busy_len", 64'(flen[0]), 64'd393);

        for (int k = 0; k < 3; k++) check_eq("idle_lines_low", 64'(viol[k]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
